seq_detector_param: RTL and testbench

//  Parametrised Moore-style serial sequence detector; successor to the fixed 5-bit detector.

---
 rtl/seq_detector_param.sv | 85 ++++++++
 tb/tb_seq_detector_param.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/seq_detector_param.sv
// Serial pattern detector with run-time programmable pattern, overlap mode, saturating match count and sticky flag.
// Latency: out pulses for one cycle, the cycle after the edge that samples the final pattern bit.
// Backpressure: none; in is consumed only when in_valid=1, idle cycles hold history and force out low.
module seq_detector_param #(
  parameter int               PAT_W   = 5,
  parameter logic [PAT_W-1:0] PATTERN = 5'b11011,
  parameter bit               OVERLAP = 1'b1,
  parameter int               CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in,
  input  logic             in_valid,
  input  logic             pat_load,
  input  logic [PAT_W-1:0] pat_in,
  input  logic             ovl_in,
  input  logic             cnt_clr,
  output logic             out,
  output logic [CNT_W-1:0] match_cnt,
  output logic             sticky
);

  localparam int FW = $clog2(PAT_W + 1);

  localparam logic [0:0] HUNT  = 1'b0;
  localparam logic [0:0] MATCH = 1'b1;

  logic [0:0]       state;
  logic [PAT_W-1:0] pattern;
  logic             mode;
  logic [PAT_W-1:0] hist;
  logic [FW-1:0]    fill;

  logic [PAT_W-1:0] nh;
  logic [FW-1:0]    nf;
  logic             hit;

  // Candidate next history/fill and match decision for a valid sample; the fill gate
  // keeps reset-zeroed history from matching before PAT_W real bits have arrived.
  always_comb begin
    nh  = {hist[PAT_W-2:0], in};
    nf  = (fill == FW'(PAT_W)) ? FW'(PAT_W) : fill + 1'b1;
    hit = in_valid && !pat_load && (nf == FW'(PAT_W)) && (nh == pattern);
  end

  // Configuration, shift history and match FSM; pat_load restarts the hunt and drops the sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      pattern <= PATTERN;
      mode    <= OVERLAP;
      hist    <= '0;
      fill    <= '0;
      state   <= HUNT;
    end else if (pat_load) begin
      pattern <= pat_in;
      mode    <= ovl_in;
      hist    <= '0;
      fill    <= '0;
      state   <= HUNT;
    end else if (in_valid) begin
      hist  <= nh;
      fill  <= (hit && !mode) ? '0 : nf;
      state <= hit ? MATCH : HUNT;
    end else begin
      state <= HUNT;
    end
  end

  // Saturating match counter and sticky flag; a clear wins over a coincident hit.
  always_ff @(posedge clk) begin
    if (rst) begin
      match_cnt <= '0;
      sticky    <= 1'b0;
    end else if (cnt_clr) begin
      match_cnt <= '0;
      sticky    <= 1'b0;
    end else if (hit) begin
      if (match_cnt != '1) match_cnt <= match_cnt + 1'b1;
      sticky <= 1'b1;
    end
  end

  assign out = (state == MATCH);

endmodule

// File: tb/tb_seq_detector_param.sv
// Bench for seq_detector_param: a default-width instance and a 2-bit-counter instance share stimulus.
// Latency: checks out/match_cnt/sticky every cycle against a queue-based reference.
// Backpressure: n/a; in_valid gaps are part of the stimulus.
module tb_seq_detector_param;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       din = 1'b0;
  logic       in_valid = 1'b0;
  logic       pat_load = 1'b0;
  logic [4:0] pat_in = 5'b0;
  logic       ovl_in = 1'b0;
  logic       cnt_clr = 1'b0;

  logic       out_a, sticky_a;
  logic [7:0] cnt_a;
  logic       out_b, sticky_b;
  logic [1:0] cnt_b;

  int vectors = 0;
  int miscompares = 0;
  int nchk = 0;

  always #5 clk = ~clk;

  seq_detector_param dut (
    .clk(clk), .rst(rst), .in(din), .in_valid(in_valid), .pat_load(pat_load),
    .pat_in(pat_in), .ovl_in(ovl_in), .cnt_clr(cnt_clr),
    .out(out_a), .match_cnt(cnt_a), .sticky(sticky_a)
  );

  seq_detector_param #(.CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .in(din), .in_valid(in_valid), .pat_load(pat_load),
    .pat_in(pat_in), .ovl_in(ovl_in), .cnt_clr(cnt_clr),
    .out(out_b), .match_cnt(cnt_b), .sticky(sticky_b)
  );

  // Reference: a queue of valid bits since the last restart, compared against the pattern.
  bit         q[$];
  logic [4:0] m_pat;
  bit         m_mode;
  bit         m_out;
  int         m_cnt8, m_cnt2;
  bit         m_sticky;
  bit         m_live = 0;

  always @(posedge clk) begin
    bit hit;
    hit = 0;
    if (rst) begin
      q.delete();
      m_pat = 5'b11011; m_mode = 1; m_out = 0;
      m_cnt8 = 0; m_cnt2 = 0; m_sticky = 0; m_live = 1;
    end else begin
      if (pat_load) begin
        m_pat = pat_in; m_mode = ovl_in; q.delete();
      end else if (in_valid) begin
        q.push_back(din);
        if (q.size() > 5) void'(q.pop_front());
        if (q.size() == 5) begin
          hit = 1;
          for (int i = 0; i < 5; i++) if (q[i] != m_pat[4-i]) hit = 0;
        end
        if (hit && !m_mode) q.delete();
      end
      m_out = hit;
      if (cnt_clr) begin
        m_cnt8 = 0; m_cnt2 = 0; m_sticky = 0;
      end else if (hit) begin
        if (m_cnt8 < 255) m_cnt8++;
        if (m_cnt2 < 3) m_cnt2++;
        m_sticky = 1;
      end
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the reference.
  always @(negedge clk) begin
    if (m_live) begin
      check("out_a", 32'(out_a), 32'(m_out));
      check("cnt_a", 32'(cnt_a), 32'(m_cnt8));
      check("sticky_a", 32'(sticky_a), 32'(m_sticky));
      check("out_b", 32'(out_b), 32'(m_out));
      check("cnt_b", 32'(cnt_b), 32'(m_cnt2));
      check("sticky_b", 32'(sticky_b), 32'(m_sticky));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    vectors++;
  endtask

  task automatic quiet();
    rst = 0; pat_load = 0; cnt_clr = 0; in_valid = 0;
  endtask

  // One valid bit, then a literal check of out on both the DUT and the reference.
  task automatic sbit(input logic b, input logic e, input string nm);
    quiet();
    din = b; in_valid = 1;
    tick();
    check(nm, 32'(out_a), 32'(e));
    check({nm, "_model"}, 32'(m_out), 32'(e));
  endtask

  task automatic stream(input logic [15:0] bits, input logic [15:0] exp, input int n, input string nm);
    for (int i = 0; i < n; i++) sbit(bits[n-1-i], exp[n-1-i], nm);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      quiet();
      tick();
      check("idle_out", 32'(out_a), 32'd0);
    end
  endtask

  task automatic load(input logic [4:0] p, input logic o);
    quiet();
    pat_load = 1; pat_in = p; ovl_in = o; din = 1; in_valid = 1;
    tick();
    quiet();
  endtask

  task automatic do_reset();
    quiet();
    rst = 1;
    tick();
    quiet();
  endtask

  task automatic clear();
    quiet();
    cnt_clr = 1;
    tick();
    quiet();
  endtask

  initial begin
    tick(); tick();
    quiet();
    check("rst_out", 32'(out_a), 32'd0);
    check("rst_cnt", 32'(cnt_a), 32'd0);
    check("rst_sticky", 32'(sticky_a), 32'd0);

    // Default pattern, overlapping: pulses after bits 5 and 8.
    stream(16'b11011011, 16'b00001001, 8, "t1_out");
    check("t1_cnt", 32'(cnt_a), 32'd2);
    check("t1_sticky", 32'(sticky_a), 32'd1);
    clear();
    check("clr_cnt", 32'(cnt_a), 32'd0);
    check("clr_sticky", 32'(sticky_a), 32'd0);

    // Non-overlapping: only the first match, next needs five fresh bits.
    load(5'b11011, 1'b0);
    stream(16'b1101101101, 16'b0000100000, 10, "t2_out");
    check("t2_cnt", 32'(cnt_a), 32'd1);

    // Runs of ones and idle gaps.
    load(5'b11011, 1'b1);
    stream(16'b111011, 16'b000001, 6, "t3a_out");
    stream(16'b110, 16'b000, 3, "t3b_out");
    idle(3);
    stream(16'b11, 16'b01, 2, "t3c_out");

    // All-zero pattern is still gated by fill.
    do_reset();
    load(5'b00000, 1'b1);
    stream(16'b000000, 16'b000011, 6, "t4_out");

    // Counter saturation on the 2-bit instance; clear coincides with a hit.
    clear();
    load(5'b11111, 1'b1);
    stream(16'b1111, 16'b0000, 4, "t5_pre");
    for (int k = 0; k < 5; k++) begin
      sbit(1'b1, 1'b1, "t5_out");
      check("t5_cnt2", 32'(cnt_b), (k < 3) ? 32'(k + 1) : 32'd3);
    end
    quiet();
    din = 1; in_valid = 1; cnt_clr = 1;
    tick();
    check("t5_clr_out", 32'(out_b), 32'd1);
    check("t5_clr_cnt", 32'(cnt_b), 32'd0);
    check("t5_clr_sticky", 32'(sticky_b), 32'd0);

    // Reset and reload mid-prefix discard the partial history.
    load(5'b11011, 1'b1);
    stream(16'b1101, 16'b0000, 4, "t6a_out");
    do_reset();
    check("t6_rst_out", 32'(out_a), 32'd0);
    check("t6_rst_cnt", 32'(cnt_a), 32'd0);
    stream(16'b11011, 16'b00001, 5, "t6b_out");
    stream(16'b1101, 16'b0000, 4, "t6c_out");
    load(5'b11011, 1'b1);
    stream(16'b11011, 16'b00001, 5, "t6d_out");

    // Randomised traffic checked by the reference every cycle.
    for (int i = 0; i < 3000; i++) begin
      rst      = ($urandom_range(0, 299) == 0);
      pat_load = ($urandom_range(0, 99) == 0);
      pat_in   = ($urandom_range(0, 1) == 1) ? 5'b11011 : 5'($urandom);
      ovl_in   = 1'($urandom_range(0, 1));
      cnt_clr  = ($urandom_range(0, 63) == 0);
      in_valid = ($urandom_range(0, 3) != 0);
      din      = 1'($urandom_range(0, 1));
      tick();
    end
    quiet();
    tick();

    if (nchk < 12) begin
      miscompares++;
      $display("FAIL too_few_checks: got %0d, expected at least 12", nchk);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
